dm_port_arbiter: RTL and testbench

Two-requester arbiter for the single-port 256x16 data memory. Shares the memory between the pipelined processor's data port and a host loader/debug port, so the host can preload operands or read results while the processor runs. Sits between `pipelinedPS` and the DM model. It stalls the processor while the host holds the port and guarantees the host a bounded wait.

---
 rtl/dm_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_dm_port_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// dm_port_arbiter
//
// Shares the single-port 256x16 data memory between the pipelined processor's
// data port and a host loader/debug port. The processor owns the port by
// default; the host takes it when the processor is idle, or after the host has
// waited STARVE_LIMIT contended cycles. While the processor is requesting, a
// host grant lasts at most MAX_BURST beats, and the processor is stalled only
// while the host owns the port.
//
// Optional feature macro: DM_ARB_STATS_EN
//   defined     -> adds stat_stall_cycles / stat_host_beats saturating counters
//   not defined -> those ports and counters do not exist
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   cpu_rd/cpu_wr/cpu_addr/
//   cpu_w_data                    processor request (zero-latency path)
//   cpu_r_data                    combinational copy of dm_r_data
//   cpu_stall                     processor must hold its memory stage
//   host_req/host_we/host_addr/
//   host_w_data                   host beat request, held until granted
//   host_gnt                      host beat accepted this cycle
//   host_rvalid/host_r_data       registered host read return (1-cycle pulse)
//   dm_addr/dm_rd/dm_wr/dm_w_data memory port, muxed from the current owner
//   dm_r_data                     memory read data
//   stat_stall_cycles             (DM_ARB_STATS_EN) cycles with cpu_stall=1
//   stat_host_beats               (DM_ARB_STATS_EN) cycles with host_gnt=1
// -----------------------------------------------------------------------------
module dm_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_BURST    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_w_data,
  output logic [DATA_WIDTH-1:0] cpu_r_data,
  output logic                  cpu_stall,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_w_data,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_r_data,
  output logic [ADDR_WIDTH-1:0] dm_addr,
  output logic                  dm_rd,
  output logic                  dm_wr,
  output logic [DATA_WIDTH-1:0] dm_w_data,
  input  logic [DATA_WIDTH-1:0] dm_r_data
`ifdef DM_ARB_STATS_EN
 ,output logic [15:0]           stat_stall_cycles
 ,output logic [15:0]           stat_host_beats
`endif
);

  localparam int unsigned SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam int unsigned BW = (MAX_BURST > 1)    ? $clog2(MAX_BURST)    : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT - 1);
  localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST - 1);

  typedef enum logic {
    OWN_CPU  = 1'b0,
    OWN_HOST = 1'b1
  } own_e;

  own_e          state_q, state_d;
  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] burst_cnt;
  logic          cpu_req;
  logic          starve_at_limit;
  logic          burst_at_limit;

  // Simultaneous rd and wr is a processor error; both are simply forwarded.
  assign cpu_req         = cpu_rd | cpu_wr;
  assign starve_at_limit = (starve_cnt == STARVE_MAX);
  assign burst_at_limit  = (burst_cnt == BURST_MAX);
  assign cpu_r_data      = dm_r_data;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= OWN_CPU;
    else      state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in a combinational block gets a default at
  // the top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OWN_CPU:  if (host_req && (!cpu_req || starve_at_limit)) state_d = OWN_HOST;
      // A grant is implied whenever host_req is high in OWN_HOST, so the burst
      // limit only needs qualifying with cpu_req.
      OWN_HOST: if (!host_req || (cpu_req && burst_at_limit))   state_d = OWN_CPU;
      default:  state_d = OWN_CPU;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: the owner alone drives the memory port.
  // ---------------------------------------------------------------------------
  always_comb begin
    dm_addr   = cpu_addr;
    dm_w_data = cpu_w_data;
    dm_rd     = cpu_rd;
    dm_wr     = cpu_wr;
    host_gnt  = 1'b0;
    cpu_stall = 1'b0;
    if (state_q == OWN_HOST) begin
      dm_addr   = host_addr;
      dm_w_data = host_w_data;
      dm_rd     = host_req & ~host_we;
      dm_wr     = host_req &  host_we;
      host_gnt  = host_req;
      cpu_stall = cpu_req;
    end
  end

  // ---------------------------------------------------------------------------
  // Fairness counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      burst_cnt  <= '0;
    end else if (state_q == OWN_CPU) begin
      if (state_d == OWN_HOST) begin
        starve_cnt <= '0;
        burst_cnt  <= '0;
      end else if (host_req && cpu_req && !starve_at_limit) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end else if (host_gnt && !burst_at_limit) begin
      // Saturates so a long host burst with an idle CPU cannot wrap and hand
      // the CPU a longer stall than MAX_BURST once it starts requesting.
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Host read return: captured at the edge ending the granted read beat.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      host_rvalid <= 1'b0;
      host_r_data <= '0;
    end else begin
      host_rvalid <= host_gnt & ~host_we;
      if (host_gnt && !host_we) host_r_data <= dm_r_data;
    end
  end

`ifdef DM_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating activity counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_stall_cycles <= '0;
      stat_host_beats   <= '0;
    end else begin
      if (cpu_stall && stat_stall_cycles != 16'hFFFF)
        stat_stall_cycles <= stat_stall_cycles + 16'd1;
      if (host_gnt && stat_host_beats != 16'hFFFF)
        stat_host_beats <= stat_host_beats + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dm_port_arbiter
//
// Directed bench for dm_port_arbiter with default parameters
// (STARVE_LIMIT=4, MAX_BURST=4). A 256x16 memory with combinational read and
// registered write sits on the dm_* port. Inputs are driven 1 time unit after
// the rising edge and outputs are sampled on the falling edge. The stats
// scenario is compiled only when DM_ARB_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_dm_port_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_rd, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_w_data, cpu_r_data;
  logic          cpu_stall;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_w_data;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_r_data;
  logic [AW-1:0] dm_addr;
  logic          dm_rd, dm_wr;
  logic [DW-1:0] dm_w_data, dm_r_data;
`ifdef DM_ARB_STATS_EN
  logic [15:0]   stat_stall_cycles, stat_host_beats;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dm_port_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_rd      (cpu_rd),
    .cpu_wr      (cpu_wr),
    .cpu_addr    (cpu_addr),
    .cpu_w_data  (cpu_w_data),
    .cpu_r_data  (cpu_r_data),
    .cpu_stall   (cpu_stall),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_w_data (host_w_data),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_r_data (host_r_data),
    .dm_addr     (dm_addr),
    .dm_rd       (dm_rd),
    .dm_wr       (dm_wr),
    .dm_w_data   (dm_w_data),
    .dm_r_data   (dm_r_data)
`ifdef DM_ARB_STATS_EN
   ,.stat_stall_cycles (stat_stall_cycles)
   ,.stat_host_beats   (stat_host_beats)
`endif
  );

  // Data memory model
  logic [DW-1:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  always @(posedge clk) if (dm_wr) mem[dm_addr] <= dm_w_data;
  assign dm_r_data = mem[dm_addr];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_w_data = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_w_data = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #2;
    @(negedge clk);
    n_checks++;
    if ({cpu_stall, host_gnt, host_rvalid} !== 3'b000) begin
      $display("FAIL reset_ctrl: stall/gnt/rvalid=%b required 000", {cpu_stall, host_gnt, host_rvalid});
      n_fail++;
    end
    n_checks++;
    if (host_r_data !== 16'h0000) begin
      $display("FAIL reset_rdata: got %h required 0000", host_r_data);
      n_fail++;
    end
    n_checks++;
    if ({dm_rd, dm_wr, dm_addr, dm_w_data} !== '0) begin
      $display("FAIL reset_dm: rd=%b wr=%b addr=%h wdata=%h required all 0", dm_rd, dm_wr, dm_addr, dm_w_data);
      n_fail++;
    end
    next_cycle();
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_cpu_only();
    cpu_wr = 1; cpu_addr = 8'd3; cpu_w_data = 16'd160;
    @(negedge clk);
    n_checks++;
    if ({cpu_stall, host_gnt} !== 2'b00) begin
      $display("FAIL cpu_wr_ctrl: stall/gnt=%b required 00", {cpu_stall, host_gnt});
      n_fail++;
    end
    n_checks++;
    if ({dm_wr, dm_addr, dm_w_data} !== {1'b1, 8'd3, 16'd160}) begin
      $display("FAIL cpu_wr_port: wr=%b addr=%0d data=%0d required 1/3/160", dm_wr, dm_addr, dm_w_data);
      n_fail++;
    end
    next_cycle();
    cpu_wr = 0; cpu_rd = 1;
    @(negedge clk);
    n_checks++;
    if (cpu_r_data !== 16'd160) begin
      $display("FAIL cpu_rd_data: got %0d required 160", cpu_r_data);
      n_fail++;
    end
    n_checks++;
    if ({cpu_stall, host_gnt, dm_rd} !== 3'b001) begin
      $display("FAIL cpu_rd_ctrl: stall/gnt/dm_rd=%b required 001", {cpu_stall, host_gnt, dm_rd});
      n_fail++;
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_host_only();
    // Cycle N: request rises, CPU still owns the port.
    host_req = 1; host_we = 1; host_addr = 8'd4; host_w_data = 16'hFFF6;
    @(negedge clk);
    n_checks++;
    if ({host_gnt, dm_wr} !== 2'b00) begin
      $display("FAIL host_n_gnt: gnt/dm_wr=%b required 00", {host_gnt, dm_wr});
      n_fail++;
    end
    next_cycle();
    // Cycle N+1: write beat granted.
    @(negedge clk);
    n_checks++;
    if ({host_gnt, dm_wr, dm_addr, dm_w_data} !== {1'b1, 1'b1, 8'd4, 16'hFFF6}) begin
      $display("FAIL host_wr_gnt: gnt=%b wr=%b addr=%0d data=%h required 1/1/4/fff6", host_gnt, dm_wr, dm_addr, dm_w_data);
      n_fail++;
    end
    next_cycle();
    // Cycle N+2: read beat granted back-to-back.
    host_we = 0;
    @(negedge clk);
    n_checks++;
    if ({host_gnt, dm_rd, host_rvalid} !== 3'b110) begin
      $display("FAIL host_rd_gnt: gnt/dm_rd/rvalid=%b required 110", {host_gnt, dm_rd, host_rvalid});
      n_fail++;
    end
    next_cycle();
    // Cycle N+3: read data returned.
    host_req = 0;
    @(negedge clk);
    n_checks++;
    if ({host_rvalid, host_r_data} !== {1'b1, 16'hFFF6}) begin
      $display("FAIL host_rvalid: rvalid=%b data=%h required 1/fff6", host_rvalid, host_r_data);
      n_fail++;
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (host_rvalid !== 1'b0) begin
      $display("FAIL host_rvalid_pulse: got %b required 0", host_rvalid);
      n_fail++;
    end
    next_cycle();
  endtask

  task automatic test_contention();
    cpu_rd = 1; cpu_addr = 8'd3;
    host_req = 1; host_we = 0; host_addr = 8'd4;
    // Starve count climbs 0..3 over cycles N..N+3; grant lands in N+4.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if ({host_gnt, cpu_stall} !== {2{c == 4}}) begin
        $display("FAIL contention_c%0d: gnt/stall=%b required %b", c, {host_gnt, cpu_stall}, {2{c == 4}});
        n_fail++;
      end
      if (c == 4) begin
        n_checks++;
        if ({dm_addr, dm_rd} !== {8'd4, 1'b1}) begin
          $display("FAIL contention_mux: addr=%0d rd=%b required 4/1", dm_addr, dm_rd);
          n_fail++;
        end
      end
      next_cycle();
    end
    host_req = 0;
    @(negedge clk);
    n_checks++;
    if ({host_rvalid, host_r_data, host_gnt} !== {1'b1, 16'hFFF6, 1'b0}) begin
      $display("FAIL contention_rdata: rvalid=%b data=%h gnt=%b required 1/fff6/0", host_rvalid, host_r_data, host_gnt);
      n_fail++;
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if ({cpu_stall, dm_addr} !== {1'b0, 8'd3}) begin
      $display("FAIL contention_return: stall=%b addr=%0d required 0/3", cpu_stall, dm_addr);
      n_fail++;
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_burst_cap();
    // Cycle 0: switch to host. Beats 1-4 in cycles 1-4 (cap hit with CPU
    // requesting). Cycles 5-8: CPU owns, starve count 0..3. Beats 5-6 in 9-10.
    logic [10:0] exp_gnt;
    int b;
    exp_gnt = 11'b11000011110; // bit c = expected grant in cycle c
    b = 0;
    for (int c = 0; c < 11; c++) begin
      cpu_rd      = (c >= 1);
      cpu_addr    = 8'd0;
      host_req    = 1;
      host_we     = 1;
      host_addr   = 8'(10 + b);
      host_w_data = 16'(16'h0100 + b);
      @(negedge clk);
      n_checks++;
      if ({host_gnt, cpu_stall} !== {2{exp_gnt[c]}}) begin
        $display("FAIL burst_c%0d: gnt/stall=%b required %b", c, {host_gnt, cpu_stall}, {2{exp_gnt[c]}});
        n_fail++;
      end
      if (exp_gnt[c]) b++;
      next_cycle();
    end
    idle_inputs();
    next_cycle();
    for (int i = 0; i < 6; i++) begin
      cpu_rd = 1; cpu_addr = 8'(10 + i);
      @(negedge clk);
      n_checks++;
      if (cpu_r_data !== 16'(16'h0100 + i)) begin
        $display("FAIL burst_mem%0d: got %h required %h", i, cpu_r_data, 16'(16'h0100 + i));
        n_fail++;
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

`ifdef DM_ARB_STATS_EN
  task automatic test_stats();
    apply_reset();
    next_cycle();
    // Grants in cycles 4,5,6; host drops in 7 while still owner, so the CPU
    // is stalled in cycles 4..7 = 4 cycles.
    for (int c = 0; c < 8; c++) begin
      cpu_rd = 1; cpu_addr = 8'd3;
      host_req = (c < 7); host_we = 0; host_addr = 8'd4;
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (stat_host_beats !== 16'd3) begin
      $display("FAIL stat_beats: got %0d required 3", stat_host_beats);
      n_fail++;
    end
    n_checks++;
    if (stat_stall_cycles !== 16'd4) begin
      $display("FAIL stat_stalls: got %0d required 4", stat_stall_cycles);
      n_fail++;
    end
    next_cycle();
  endtask
`endif

  task automatic test_reset_mid_burst();
    host_req = 1; host_we = 0; host_addr = 8'd4;
    next_cycle();
    cpu_rd = 1; cpu_addr = 8'd7;
    @(negedge clk);
    n_checks++;
    if ({host_gnt, cpu_stall} !== 2'b11) begin
      $display("FAIL midrst_pre: gnt/stall=%b required 11", {host_gnt, cpu_stall});
      n_fail++;
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({cpu_stall, host_gnt, host_rvalid} !== 3'b000) begin
      $display("FAIL midrst_ctrl: stall/gnt/rvalid=%b required 000", {cpu_stall, host_gnt, host_rvalid});
      n_fail++;
    end
    n_checks++;
    if ({dm_addr, dm_rd} !== {8'd7, 1'b1}) begin
      $display("FAIL midrst_mux: addr=%0d rd=%b required 7/1", dm_addr, dm_rd);
      n_fail++;
    end
    next_cycle();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (host_rvalid !== 1'b0) begin
      $display("FAIL midrst_drop: rvalid=%b required 0", host_rvalid);
      n_fail++;
    end
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cpu_only();
    test_host_only();
    test_contention();
    test_burst_cap();
`ifdef DM_ARB_STATS_EN
    test_stats();
`endif
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
